xbar_socket_1n: RTL and testbench

- Parametrised 1-to-N TL-UL device-side socket: decodes each host A-channel request against per-device base/mask arrays and steers it to one of N devices.
- Tracks outstanding requests so that responses return in order.
- Answers unmapped addresses with an internal error responder.
- Sits between each host port (instruction fetch, LSU) and the peripheral fabric. Replaces hard-coded per-device address decode with N generic, parametrised ports.

---
 rtl/xbar_socket_1n.sv | 189 ++++++++++++++++++
 tb/tb_xbar_socket_1n.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_socket_1n.sv
// xbar_socket_1n
//   1-to-N TL-UL device-side socket. Each host A-channel request is decoded
//   against per-device base/mask pairs and steered to exactly one device, or
//   to an internal error responder when no device claims the address.
//   Outstanding requests all target the same port, so responses come back
//   in request order without any reorder storage.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   a_*_i / a_ready_o       host A channel (request)
//   d_*_o / d_ready_i       host D channel (response)
//   dev_a_valid_o           one-hot request valid per device
//   dev_a_*_o               host A fields broadcast to every device
//   dev_a_ready_i           per-device A ready
//   dev_d_*_i               per-device D channel, packed N-wide
//   dev_d_ready_o           D ready, only towards the pending device
//
// Error responder states
//   state    | meaning
//   ERR_IDLE | no error response owed, can accept an unmapped request
//   ERR_RESP | presenting the error response, waiting for d_ready_i
module xbar_socket_1n #(
  parameter int N              = 12,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = 8,
  parameter int MaxOutstanding = 4,
  parameter logic [N-1:0][AW-1:0] AddrSpace = '0,
  parameter logic [N-1:0][AW-1:0] AddrMask  = {N{AW'(32'h0000ffff)}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  input  logic [2:0]        a_opcode_i,
  input  logic [AW-1:0]     a_address_i,
  input  logic [DW-1:0]     a_data_i,
  input  logic [DW/8-1:0]   a_mask_i,
  input  logic [SW-1:0]     a_source_i,
  output logic              a_ready_o,
  output logic              d_valid_o,
  output logic [2:0]        d_opcode_o,
  output logic [DW-1:0]     d_data_o,
  output logic [SW-1:0]     d_source_o,
  output logic              d_error_o,
  input  logic              d_ready_i,
  output logic [N-1:0]      dev_a_valid_o,
  output logic [2:0]        dev_a_opcode_o,
  output logic [AW-1:0]     dev_a_address_o,
  output logic [DW-1:0]     dev_a_data_o,
  output logic [DW/8-1:0]   dev_a_mask_o,
  output logic [SW-1:0]     dev_a_source_o,
  input  logic [N-1:0]      dev_a_ready_i,
  input  logic [N-1:0]      dev_d_valid_i,
  input  logic [N*3-1:0]    dev_d_opcode_i,
  input  logic [N*DW-1:0]   dev_d_data_i,
  input  logic [N*SW-1:0]   dev_d_source_i,
  input  logic [N-1:0]      dev_d_error_i,
  output logic [N-1:0]      dev_d_ready_o
);

  localparam int TW = $clog2(N + 1);
  localparam int CW = 4;
  localparam logic [2:0] OpGet = 3'd4;

  typedef logic [TW-1:0] tgt_t;
  localparam tgt_t ErrTgt = tgt_t'(N);

  typedef enum logic {ERR_IDLE, ERR_RESP} err_state_t;

  err_state_t      err_state, err_next;
  logic [SW-1:0]   err_source;
  logic            err_get;
  logic [CW-1:0]   count;
  tgt_t            pending;
  tgt_t            sel;
  logic            dev_rdy_sel;
  logic            tgt_ready;
  logic            has_room;
  logic            issue;
  logic            accept;
  logic            d_hs;
  logic            busy;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    sel = ErrTgt;
    for (int i = N - 1; i >= 0; i--) begin
      if ((a_address_i & ~AddrMask[i]) == AddrSpace[i]) sel = tgt_t'(i);
    end
  end

  always_comb begin
    dev_rdy_sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == tgt_t'(i)) dev_rdy_sel = dev_a_ready_i[i];
    end
  end

  assign busy      = (count != '0);
  assign tgt_ready = (sel == ErrTgt) ? (err_state == ERR_IDLE) : dev_rdy_sel;
  // Registered count only; a response completing this cycle does not unstall.
  assign has_room  = (count < CW'(MaxOutstanding)) && (!busy || (sel == pending));
  // rst_ni gating keeps the handshake outputs low throughout reset.
  assign issue     = rst_ni && a_valid_i && has_room;
  assign accept    = issue && tgt_ready;
  assign a_ready_o = accept;

  always_comb begin
    dev_a_valid_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == tgt_t'(i)) dev_a_valid_o[i] = issue;
    end
  end

  assign dev_a_opcode_o  = a_opcode_i;
  assign dev_a_address_o = a_address_i;
  assign dev_a_data_o    = a_data_i;
  assign dev_a_mask_o    = a_mask_i;
  assign dev_a_source_o  = a_source_i;

  always_comb begin
    d_valid_o     = 1'b0;
    d_opcode_o    = 3'd0;
    d_data_o      = '0;
    d_source_o    = '0;
    d_error_o     = 1'b0;
    dev_d_ready_o = '0;
    if (busy) begin
      if (pending == ErrTgt) begin
        d_valid_o  = (err_state == ERR_RESP);
        d_error_o  = 1'b1;
        d_opcode_o = err_get ? 3'd1 : 3'd0;
        d_data_o   = err_get ? '1 : '0;
        d_source_o = err_source;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (pending == tgt_t'(i)) begin
            d_valid_o        = dev_d_valid_i[i];
            d_opcode_o       = dev_d_opcode_i[i*3 +: 3];
            d_data_o         = dev_d_data_i[i*DW +: DW];
            d_source_o       = dev_d_source_i[i*SW +: SW];
            d_error_o        = dev_d_error_i[i];
            dev_d_ready_o[i] = d_ready_i;
          end
        end
      end
    end
  end

  assign d_hs = d_valid_o && d_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count   <= '0;
      pending <= ErrTgt;
    end else begin
      case ({accept, d_hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept) pending <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_state  <= ERR_IDLE;
      err_source <= '0;
      err_get    <= 1'b0;
    end else begin
      err_state <= err_next;
      if (accept && (sel == ErrTgt)) begin
        err_source <= a_source_i;
        err_get    <= (a_opcode_i == OpGet);
      end
    end
  end

  always_comb begin
    err_next = err_state;
    case (err_state)
      ERR_IDLE: if (accept && (sel == ErrTgt)) err_next = ERR_RESP;
      ERR_RESP: if (d_ready_i) err_next = ERR_IDLE;
      default:  err_next = ERR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xbar_socket_1n.sv
`timescale 1ns/1ps
module tb_xbar_socket_1n;
  localparam int N = 12, AW = 32, DW = 32, SW = 8, MAXO = 4;
  localparam logic [N-1:0][AW-1:0] BASE = {
    32'h40080000, 32'h400A0000, 32'h40070000, 32'h40060000,
    32'h40050000, 32'h40040000, 32'h40030000, 32'h40020000,
    32'h40090000, 32'h40080000, 32'h40010000, 32'h40000000};
  localparam logic [N-1:0][AW-1:0] MASK = {N{32'h0000ffff}};

  logic clk = 1'b0;
  logic rst_n;
  logic a_valid_i, a_ready_o, d_valid_o, d_error_o, d_ready_i;
  logic [2:0] a_opcode_i, d_opcode_o, dev_a_opcode_o;
  logic [AW-1:0] a_address_i, dev_a_address_o;
  logic [DW-1:0] a_data_i, d_data_o, dev_a_data_o;
  logic [DW/8-1:0] a_mask_i, dev_a_mask_o;
  logic [SW-1:0] a_source_i, d_source_o, dev_a_source_o;
  logic [N-1:0] dev_a_valid_o, dev_a_ready_i, dev_d_valid_i, dev_d_error_i, dev_d_ready_o;
  logic [N*3-1:0] dev_d_opcode_i;
  logic [N*DW-1:0] dev_d_data_i;
  logic [N*SW-1:0] dev_d_source_i;

  always #5 clk = ~clk;

  xbar_socket_1n #(.N(N), .AW(AW), .DW(DW), .SW(SW), .MaxOutstanding(MAXO),
                   .AddrSpace(BASE), .AddrMask(MASK)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid_i), .a_opcode_i(a_opcode_i), .a_address_i(a_address_i),
    .a_data_i(a_data_i), .a_mask_i(a_mask_i), .a_source_i(a_source_i), .a_ready_o(a_ready_o),
    .d_valid_o(d_valid_o), .d_opcode_o(d_opcode_o), .d_data_o(d_data_o),
    .d_source_o(d_source_o), .d_error_o(d_error_o), .d_ready_i(d_ready_i),
    .dev_a_valid_o(dev_a_valid_o), .dev_a_opcode_o(dev_a_opcode_o),
    .dev_a_address_o(dev_a_address_o), .dev_a_data_o(dev_a_data_o),
    .dev_a_mask_o(dev_a_mask_o), .dev_a_source_o(dev_a_source_o),
    .dev_a_ready_i(dev_a_ready_i), .dev_d_valid_i(dev_d_valid_i),
    .dev_d_opcode_i(dev_d_opcode_i), .dev_d_data_i(dev_d_data_i),
    .dev_d_source_i(dev_d_source_i), .dev_d_error_i(dev_d_error_i),
    .dev_d_ready_o(dev_d_ready_o));

  typedef struct {
    logic [SW-1:0] src;
    logic [2:0]    op;
    logic [DW-1:0] data;
    logic          err;
    logic          chk_data;
  } rsp_t;
  typedef struct {
    int   tgt;
    rsp_t r;
  } dreq_t;

  rsp_t  exp_q[$];
  dreq_t dq[$];
  rsp_t  mon_e;

  int n_checks = 0, n_pass = 0;
  int outst = 0, pend = N;
  bit presenting = 0, last_acc = 0, spur_en = 0, rand_mode = 0, dir_en = 0;
  logic [DW-1:0] dir_data = '0;
  logic [N-1:0] mute = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Address map rule: first device whose unmasked bits equal its base.
  function automatic int decode(input logic [AW-1:0] addr);
    for (int i = 0; i < N; i++)
      if ((addr & ~MASK[i]) == BASE[i]) return i;
    return N;
  endfunction

  task automatic drive_dev();
    int ft;
    ft = (dq.size() > 0) ? dq[0].tgt : -1;
    if (!presenting && ft >= 0) begin
      if (!mute[ft] && $urandom_range(0, 99) < 60) presenting = 1;
    end
    for (int j = 0; j < N; j++) begin
      dev_d_valid_i[j]           = 1'b0;
      dev_d_opcode_i[j*3 +: 3]   = 3'($urandom);
      dev_d_data_i[j*DW +: DW]   = $urandom;
      dev_d_source_i[j*SW +: SW] = SW'($urandom);
      dev_d_error_i[j]           = 1'($urandom);
      if (spur_en && j != ft && $urandom_range(0, 9) == 0) dev_d_valid_i[j] = 1'b1;
    end
    if (presenting) begin
      dev_d_valid_i[ft]           = 1'b1;
      dev_d_opcode_i[ft*3 +: 3]   = dq[0].r.op;
      dev_d_data_i[ft*DW +: DW]   = dq[0].r.data;
      dev_d_source_i[ft*SW +: SW] = dq[0].r.src;
      dev_d_error_i[ft]           = dq[0].r.err;
    end
  endtask

  task automatic check_cycle();
    int tgt;
    bit room, exp_rdy, exp_dv, acc, dhs;
    logic [N-1:0] exp_dav, exp_ddr;
    rsp_t r;
    dreq_t q;
    tgt = decode(a_address_i);
    room = (outst < MAXO) && (outst == 0 || pend == tgt);
    exp_dav = '0;
    exp_ddr = '0;
    if (tgt == N) exp_rdy = a_valid_i && (outst == 0);
    else begin
      exp_rdy = a_valid_i && room && dev_a_ready_i[tgt];
      if (a_valid_i && room) exp_dav[tgt] = 1'b1;
    end
    exp_dv = (outst > 0) && (pend == N || dev_d_valid_i[pend]);
    if (outst > 0 && pend < N && d_ready_i) exp_ddr[pend] = 1'b1;
    chk("a_ready", a_ready_o, exp_rdy);
    chk("dev_a_valid", dev_a_valid_o, exp_dav);
    chk("d_valid", d_valid_o, exp_dv);
    chk("dev_d_ready", dev_d_ready_o, exp_ddr);
    chk("dev_a_addr", dev_a_address_o, a_address_i);
    chk("dev_a_source", dev_a_source_o, a_source_i);

    acc = a_valid_i && a_ready_o;
    dhs = d_valid_o && d_ready_i;
    last_acc = acc;
    if (presenting && dev_d_ready_o[dq[0].tgt]) begin
      void'(dq.pop_front());
      presenting = 0;
    end
    if (acc) begin
      r.src = a_source_i;
      r.op  = (a_opcode_i == 3'd4) ? 3'd1 : 3'd0;
      if (tgt == N) begin
        r.data = '1; r.err = 1'b1; r.chk_data = (a_opcode_i == 3'd4);
      end else begin
        r.data = dir_en ? dir_data : $urandom;
        r.err  = dir_en ? 1'b0 : ($urandom_range(0, 7) == 0);
        r.chk_data = 1'b1;
        q.tgt = tgt; q.r = r;
        dq.push_back(q);
      end
      exp_q.push_back(r);
      pend = tgt;
    end
    outst = outst + (acc ? 1 : 0) - (dhs ? 1 : 0);
  endtask

  task automatic step();
    if (rand_mode) begin
      dev_a_ready_i = N'($urandom | $urandom);
      d_ready_i     = ($urandom_range(0, 3) != 0);
    end
    drive_dev();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [AW-1:0] addr, input logic [2:0] op, input logic [SW-1:0] src);
    a_valid_i = 1'b1; a_address_i = addr; a_opcode_i = op; a_source_i = src;
    a_data_i = $urandom; a_mask_i = '1;
  endtask

  task automatic wait_acc(input int max_cyc, output bit ok);
    ok = 0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      step();
      ok = last_acc;
    end
    if (ok) a_valid_i = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic [2:0] op, input logic [SW-1:0] src, output bit ok);
    drive_req(addr, op, src);
    wait_acc(2, ok);
    a_valid_i = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    a_valid_i = 1'b0;
    for (int k = 0; k < max_cyc && exp_q.size() > 0; k++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every D handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && d_valid_o && d_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_d: got source %0h with nothing outstanding, expected no response", d_source_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("d_source", d_source_o, mon_e.src);
        chk("d_opcode", d_opcode_o, mon_e.op);
        chk("d_error", d_error_o, mon_e.err);
        if (mon_e.chk_data) chk("d_data", d_data_o, mon_e.data);
      end
    end
  end

  initial begin
    bit ok;
    logic [DW-1:0] hold_data;
    rst_n = 1'b0;
    a_valid_i = 0; a_opcode_i = 0; a_address_i = 0; a_data_i = 0; a_mask_i = 0; a_source_i = 0;
    d_ready_i = 1'b1; dev_a_ready_i = '1;
    dev_d_valid_i = '0; dev_d_opcode_i = '0; dev_d_data_i = '0; dev_d_source_i = '0; dev_d_error_i = '0;
    repeat (3) @(posedge clk);
    a_valid_i = 1'b1; a_address_i = 32'h40000000;
    #1;
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_dev_a_valid", dev_a_valid_o, 0);
    chk("rst_d_valid", d_valid_o, 0);
    a_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mapped Get to device 3 with a known read value.
    dir_en = 1; dir_data = 32'hCAFEF00D;
    drive_req(32'h40090010, 3'd4, 8'h11);
    #1 chk("dev3_sel", dev_a_valid_o, 12'h008);
    wait_acc(2, ok); chk("dev3_acc", ok, 1);
    drain(50);
    dir_en = 0;

    // Duplicate base: device 2 wins over device 11.
    drive_req(32'h40080004, 3'd0, 8'h22);
    #1 chk("dup_sel", dev_a_valid_o, 12'h004);
    wait_acc(2, ok); chk("dup_acc", ok, 1);
    drain(50);

    // Unmapped Get: error response one cycle later, stable under backpressure.
    d_ready_i = 1'b0;
    drive_req(32'h50000000, 3'd4, 8'h33);
    #1 chk("err_a_ready", a_ready_o, 1);
    wait_acc(1, ok); chk("err_acc", ok, 1);
    #1;
    chk("err_d_valid", d_valid_o, 1);
    chk("err_d_error", d_error_o, 1);
    chk("err_d_opcode", d_opcode_o, 1);
    chk("err_d_data", d_data_o, 32'hFFFFFFFF);
    chk("err_d_source", d_source_o, 8'h33);
    hold_data = d_data_o;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("err_hold_valid", d_valid_o, 1);
      chk("err_hold_data", d_data_o, 32'hFFFFFFFF);
      chk("err_hold_source", d_source_o, 8'h33);
    end
    d_ready_i = 1'b1;
    drain(10);

    // Outstanding limit against a silent device 1.
    mute[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'h40010000 + 32'(k * 4), 3'd4, SW'(k), ok);
      chk("limit_acc", ok, 1);
    end
    drive_req(32'h40010040, 3'd4, 8'h05);
    wait_acc(6, ok); chk("limit_stall", ok, 0);
    mute[1] = 1'b0;
    wait_acc(60, ok); chk("limit_release", ok, 1);
    a_valid_i = 1'b0;
    drain(200);

    // Target switch stalls until device 0 has answered.
    mute[0] = 1'b1;
    send(32'h40000100, 3'd0, 8'h06, ok); chk("sw_first", ok, 1);
    drive_req(32'h40080008, 3'd4, 8'h07);
    wait_acc(5, ok); chk("sw_stall", ok, 0);
    mute[0] = 1'b0;
    wait_acc(60, ok); chk("sw_release", ok, 1);
    a_valid_i = 1'b0;
    drain(200);

    // Reset with three requests in flight.
    mute[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(32'h40030000 + 32'(k * 8), 3'd4, SW'(8'h40 + k), ok);
      chk("rst_fill", ok, 1);
    end
    a_valid_i = 1'b1; a_address_i = 32'h40030000;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_ready", a_ready_o, 0);
    chk("midrst_dev_a_valid", dev_a_valid_o, 0);
    chk("midrst_d_valid", d_valid_o, 0);
    chk("midrst_dev_d_ready", dev_d_ready_o, 0);
    exp_q.delete(); dq.delete();
    outst = 0; pend = N; presenting = 0; mute = '0;
    a_valid_i = 1'b0; dev_d_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_req(32'h40020010, 3'd4, 8'h09);
    #1 chk("post_rst_sel", dev_a_valid_o, 12'h010);
    wait_acc(2, ok); chk("post_rst_acc", ok, 1);
    drain(100);

    // Randomised traffic against the reference model.
    spur_en = 1; rand_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!a_valid_i && $urandom_range(0, 99) < 70) begin
        int di;
        logic [AW-1:0] addr;
        logic [2:0] op;
        di = $urandom_range(0, N);
        if (di < N) addr = BASE[di] | (32'($urandom) & 32'h0000fffc);
        else addr = 32'h50000000 | (32'($urandom) & 32'h000ffffc);
        case ($urandom_range(0, 2))
          0: op = 3'd0;
          1: op = 3'd1;
          default: op = 3'd4;
        endcase
        drive_req(addr, op, SW'($urandom));
      end
      step();
      if (last_acc) a_valid_i = 1'b0;
    end
    rand_mode = 0; dev_a_ready_i = '1; d_ready_i = 1'b1;
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
